// File: rtl/hud_pkg.sv
// rtl/hud_pkg.sv - shared state, player and BCD digit definitions for the HUD
package hud_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } hud_state_t;

    localparam logic [3:0] PLAYER_NONE = 4'd0;
    localparam logic [3:0] PLAYER_1    = 4'd1;
    localparam logic [3:0] PLAYER_2    = 4'd2;

    localparam logic [3:0] BCD_ZERO = 4'd0;
    localparam logic [3:0] BCD_NINE = 4'd9;

    function automatic logic [3:0] bcd_inc_sat(input logic [3:0] d);
        return (d >= BCD_NINE) ? BCD_NINE : d + 4'd1;
    endfunction

    function automatic logic [3:0] other_player(input logic [3:0] p);
        return (p == PLAYER_1) ? PLAYER_2 : PLAYER_1;
    endfunction

endpackage

// File: rtl/turn_timer.sv
// rtl/turn_timer.sv - two-digit BCD turn down-counter with reload and decrement
module turn_timer
    import hud_pkg::*;
#(
    parameter int TURN_SECS = 15
)
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_load,
    input  logic       i_dec,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones,
    output logic       o_zero
);

    localparam logic [3:0] RELOAD_TENS = 4'(TURN_SECS / 10);
    localparam logic [3:0] RELOAD_ONES = 4'(TURN_SECS % 10);

    logic [3:0] r_tens;
    logic [3:0] r_ones;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tens <= RELOAD_TENS;
            r_ones <= RELOAD_ONES;
        end else if (i_load) begin
            r_tens <= RELOAD_TENS;
            r_ones <= RELOAD_ONES;
        end else if (i_dec && !o_zero) begin
            // Borrow from the tens digit when the ones digit rolls under zero
            if (r_ones == BCD_ZERO) begin
                r_ones <= BCD_NINE;
                r_tens <= r_tens - 4'd1;
            end else begin
                r_ones <= r_ones - 4'd1;
            end
        end
    end

    assign o_tens = r_tens;
    assign o_ones = r_ones;
    assign o_zero = (r_tens == BCD_ZERO) && (r_ones == BCD_ZERO);

endmodule

// File: rtl/hud_controller.sv
// rtl/hud_controller.sv - two-player game HUD: FSM, scores, prescaler and turn timer
module hud_controller
    import hud_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int TURN_SECS = 15
)
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       match,
    input  logic       miss,
    input  logic       game_over,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [3:0] player,
    output logic [3:0] timer_tens,
    output logic [3:0] timer_ones,
    output logic [3:0] winner,
    output logic       playing
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    hud_state_t    r_state;
    logic [3:0]    r_p1;
    logic [3:0]    r_p2;
    logic [3:0]    r_player;
    logic [3:0]    r_winner;
    logic          r_playing;
    logic [PW-1:0] r_presc;
    logic          r_armed;

    logic w_in_play;
    logic w_start_ok;
    logic w_event;
    logic w_tick;
    logic w_timer_zero;
    logic w_timeout;
    logic w_load;
    logic w_dec;

    // r_armed masks the first edge after reset release so stray pulses are dropped
    assign w_in_play  = r_armed && (r_state == ST_PLAY);
    assign w_start_ok = r_armed && (r_state != ST_PLAY) && start;
    assign w_event    = game_over || match || miss;
    assign w_tick     = w_in_play && (r_presc == PRESC_LAST);
    assign w_timeout  = w_tick && !w_event && w_timer_zero;
    assign w_load     = w_start_ok || (w_in_play && !game_over && (match || miss)) || w_timeout;
    assign w_dec      = w_tick && !w_event && !w_timer_zero;

    turn_timer #(
        .TURN_SECS (TURN_SECS)
    ) u_turn_timer (
        .clk    (clk),
        .resetn (resetn),
        .i_load (w_load),
        .i_dec  (w_dec),
        .o_tens (timer_tens),
        .o_ones (timer_ones),
        .o_zero (w_timer_zero)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_p1      <= BCD_ZERO;
            r_p2      <= BCD_ZERO;
            r_player  <= PLAYER_1;
            r_winner  <= PLAYER_NONE;
            r_playing <= 1'b0;
            r_presc   <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (r_armed) begin
                unique case (r_state)
                    ST_IDLE, ST_OVER: begin
                        if (start) begin
                            r_state   <= ST_PLAY;
                            r_playing <= 1'b1;
                            r_p1      <= BCD_ZERO;
                            r_p2      <= BCD_ZERO;
                            r_player  <= PLAYER_1;
                            r_winner  <= PLAYER_NONE;
                            r_presc   <= '0;
                        end
                    end
                    ST_PLAY: begin
                        if (game_over) begin
                            r_state   <= ST_OVER;
                            r_playing <= 1'b0;
                            r_winner  <= (r_p1 > r_p2) ? PLAYER_1 :
                                         (r_p2 > r_p1) ? PLAYER_2 : PLAYER_NONE;
                        end else if (match) begin
                            if (r_player == PLAYER_1) r_p1 <= bcd_inc_sat(r_p1);
                            else                      r_p2 <= bcd_inc_sat(r_p2);
                            r_presc <= '0;
                        end else if (miss) begin
                            r_player <= other_player(r_player);
                            r_presc  <= '0;
                        end else begin
                            r_presc <= w_tick ? '0 : r_presc + PW'(1);
                            if (w_timeout) r_player <= other_player(r_player);
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_playing <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign p1_score = r_p1;
    assign p2_score = r_p2;
    assign player   = r_player;
    assign winner   = r_winner;
    assign playing  = r_playing;

endmodule

// File: tb/tb_hud_controller.sv
// tb/tb_hud_controller.sv - self-checking bench for hud_controller against a behavioural game model
module tb_hud_controller;

    localparam int TICK_DIV  = 4;
    localparam int TURN_SECS = 15;

    logic       clk;
    logic       resetn;
    logic       start;
    logic       match;
    logic       miss;
    logic       game_over;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [3:0] player;
    logic [3:0] timer_tens;
    logic [3:0] timer_ones;
    logic [3:0] winner;
    logic       playing;

    hud_controller #(
        .TICK_DIV  (TICK_DIV),
        .TURN_SECS (TURN_SECS)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .match      (match),
        .miss       (miss),
        .game_over  (game_over),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .player     (player),
        .timer_tens (timer_tens),
        .timer_ones (timer_ones),
        .winner     (winner),
        .playing    (playing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Game model: timer held as a plain seconds count, prescaler as cycles since last clear
    int m_p1, m_p2, m_player, m_timer, m_winner, m_cnt;
    bit m_playing, m_armed;

    int    n_checks = 0;
    int    n_errors = 0;
    bit    pin_valid = 1'b0;
    string pin_tag = "";
    int    pin_p1, pin_p2, pin_player, pin_timer, pin_winner, pin_playing;

    task automatic model_reset();
        m_p1 = 0; m_p2 = 0; m_player = 1; m_timer = TURN_SECS;
        m_winner = 0; m_cnt = 0; m_playing = 1'b0; m_armed = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit m, input bit x, input bit g);
        if (!m_armed) begin
            m_armed = 1'b1;
            return;
        end
        if (!m_playing) begin
            if (s) begin
                m_playing = 1'b1; m_p1 = 0; m_p2 = 0; m_player = 1;
                m_timer = TURN_SECS; m_winner = 0; m_cnt = 0;
            end
        end else if (g) begin
            m_playing = 1'b0;
            m_winner  = (m_p1 > m_p2) ? 1 : ((m_p2 > m_p1) ? 2 : 0);
        end else if (m) begin
            if (m_player == 1) m_p1 = (m_p1 < 9) ? m_p1 + 1 : 9;
            else               m_p2 = (m_p2 < 9) ? m_p2 + 1 : 9;
            m_timer = TURN_SECS;
            m_cnt   = 0;
        end else if (x) begin
            m_player = 3 - m_player;
            m_timer  = TURN_SECS;
            m_cnt    = 0;
        end else begin
            m_cnt++;
            if (m_cnt == TICK_DIV) begin
                m_cnt = 0;
                if (m_timer > 0) m_timer--;
                else begin
                    m_player = 3 - m_player;
                    m_timer  = TURN_SECS;
                end
            end
        end
    endtask

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Compare process: DUT against model every falling edge and on async reset assertion
    always begin
        @(negedge clk or negedge resetn);
        #1;
        chk("p1_score", int'(p1_score), m_p1);
        chk("p2_score", int'(p2_score), m_p2);
        chk("player", int'(player), m_player);
        chk("timer_tens", int'(timer_tens), m_timer / 10);
        chk("timer_ones", int'(timer_ones), m_timer % 10);
        chk("winner", int'(winner), m_winner);
        chk("playing", int'(playing), int'(m_playing));
        if (pin_valid) begin
            chk({pin_tag, ".p1"}, int'(p1_score), pin_p1);
            chk({pin_tag, ".p2"}, int'(p2_score), pin_p2);
            chk({pin_tag, ".player"}, int'(player), pin_player);
            chk({pin_tag, ".timer"}, int'(timer_tens) * 10 + int'(timer_ones), pin_timer);
            chk({pin_tag, ".winner"}, int'(winner), pin_winner);
            chk({pin_tag, ".playing"}, int'(playing), pin_playing);
        end
    end

    task automatic pin(input string tag, input int p1, input int p2, input int pl,
                       input int tm, input int w, input int pg);
        pin_tag = tag; pin_p1 = p1; pin_p2 = p2; pin_player = pl;
        pin_timer = tm; pin_winner = w; pin_playing = pg;
        pin_valid = 1'b1;
    endtask

    task automatic step(input bit s, input bit m, input bit x, input bit g);
        @(negedge clk);
        #2;
        pin_valid = 1'b0;
        start = s; match = m; miss = x; game_over = g;
        @(posedge clk);
        if (resetn) model_step(s, m, x, g);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic release_reset(input bit s, input bit m);
        @(negedge clk);
        #2;
        pin_valid = 1'b0;
        resetn = 1'b1;
        start = s; match = m; miss = 1'b0; game_over = 1'b0;
        @(posedge clk);
        model_step(s, m, 1'b0, 1'b0);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; match = 1'b0; miss = 1'b0; game_over = 1'b0;
        model_reset();
        pin("reset", 0, 0, 1, 15, 0, 0);
        idle(2);
        release_reset(1'b1, 1'b0);
        pin("release_start_ignored", 0, 0, 1, 15, 0, 0);

        // Countdown and timeout
        step(1'b1, 1'b0, 1'b0, 1'b0);
        pin("start", 0, 0, 1, 15, 0, 1);
        idle(4);
        pin("first_tick", 0, 0, 1, 14, 0, 1);
        idle(56);
        pin("timer_zero", 0, 0, 1, 0, 0, 1);
        idle(4);
        pin("timeout", 0, 0, 2, 15, 0, 1);

        step(1'b0, 1'b0, 1'b0, 1'b1);
        pin("over_tie0", 0, 0, 2, 15, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        pin("restart", 0, 0, 1, 15, 0, 1);

        // Scoring sequence with reloads after partial countdowns
        for (int i = 1; i <= 3; i++) begin
            idle(5);
            step(1'b0, 1'b1, 1'b0, 1'b0);
            pin("match_seq", i, 0, 1, 15, 0, 1);
        end
        idle(3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        pin("miss_seq", 3, 0, 2, 15, 0, 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        pin("p2_match", 3, 1, 2, 15, 0, 1);

        // Same-cycle priority
        step(1'b0, 1'b0, 1'b1, 1'b0);
        pin("miss_back", 3, 1, 1, 15, 0, 1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        pin("match_beats_miss", 4, 1, 1, 15, 0, 1);
        idle(3);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        pin("match_beats_tick", 5, 1, 1, 15, 0, 1);
        idle(4);
        pin("tick_after", 5, 1, 1, 14, 0, 1);

        // Saturation and freeze after game over
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        pin("saturate", 9, 1, 1, 15, 0, 1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        pin("over_p1", 9, 1, 1, 15, 1, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(8);
        pin("frozen", 9, 1, 1, 15, 1, 0);

        // Tie game, with start ignored during PLAY
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        pin("start_in_play", 2, 0, 1, 15, 0, 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        pin("tie", 2, 2, 2, 15, 0, 0);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        pin("p2_wins", 0, 1, 2, 15, 2, 0);

        // Asynchronous reset mid-game
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(32);
        pin("pre_reset", 0, 4, 2, 7, 0, 1);
        @(negedge clk);
        #2;
        pin("async_reset", 0, 0, 1, 15, 0, 0);
        resetn = 1'b0;
        model_reset();
        idle(2);
        release_reset(1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        pin("match_after_reset", 0, 0, 1, 15, 0, 0);
        idle(2);

        @(negedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hud_controller.md
HUD_CONTROLLER -- requirements
Module: hud_controller

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter TICK_DIV, default 50000000: clk cycles per one-second timer tick.
REQ-003 Parameter TURN_SECS, default 15: turn timer reload value, two BCD digits, range 1..99.
REQ-004 Port clk  input  1  system clock, rising edge.
REQ-005 Port resetn  input  1  asynchronous active-low reset.
REQ-006 Port start  input  1  one-cycle pulse; begins a new game.
REQ-007 Port match  input  1  one-cycle pulse; current player found a pair.
REQ-008 Port miss  input  1  one-cycle pulse; current player failed a pair.
REQ-009 Port game_over  input  1  one-cycle pulse; all pairs cleared.
REQ-010 Port p1_score, p2_score  output  4 each  BCD score digits.
REQ-011 Port player  output  4  current player digit, 1 or 2.
REQ-012 Port timer_tens, timer_ones  output  4 each  BCD turn timer digits.
REQ-013 Port winner  output  4  1 or 2 = winner; 0 = none or tie.
REQ-014 Port playing  output  1  high while in PLAY.

Function
REQ-015 All outputs SHALL be registered and change only on a rising clk edge or on reset.
REQ-016 FSM states SHALL be IDLE, PLAY, OVER; IDLE->PLAY on start; PLAY->OVER on game_over; OVER->PLAY on start; no other transitions.
REQ-017 On start in IDLE or OVER: scores := 0, player := 1, timer := TURN_SECS, winner := 0, prescaler := 0.
REQ-018 In IDLE and OVER all counters SHALL hold; match, miss and game_over SHALL be ignored; start in PLAY SHALL be ignored.
REQ-019 In PLAY the prescaler SHALL count 0..TICK_DIV-1 and wrap; the cycle it equals TICK_DIV-1 is a tick.
REQ-020 On tick with timer > 00: timer SHALL decrement by one in BCD (x0 -> (x-1)9), visible the next cycle.
REQ-021 On tick with timer = 00: player SHALL toggle and timer SHALL reload TURN_SECS (timeout).
REQ-022 On match: current player's score SHALL increment by one, saturating at 9; player unchanged; timer reloads; prescaler clears.
REQ-023 On miss: player SHALL toggle; timer reloads; prescaler clears.
REQ-024 Same-cycle priority SHALL be game_over > match > miss > tick; lower-priority events that cycle are discarded.
REQ-025 On game_over: winner := player with higher score, 0 on tie; scores, player and timer freeze at their values.
REQ-026 playing SHALL be 1 exactly when state = PLAY.
REQ-027 All digit outputs SHALL remain in 0..9 at all times.

Reset
REQ-028 resetn low SHALL immediately force state IDLE, p1_score 0, p2_score 0, player 1, timer TURN_SECS, winner 0, prescaler 0, playing 0.
REQ-029 Reset asserted mid-game SHALL abandon the game; after release the block SHALL wait for start.
REQ-030 Inputs pulsed in the cycle resetn deasserts SHALL be ignored.

Structure
REQ-031 A shared package hud_pkg SHALL hold the state encoding, player codes (1, 2, 0 = none), and BCD digit constants; the decoder side SHALL import the same package.
REQ-032 The BCD two-digit down-counter with load and tick SHALL be a sub-module named turn_timer; FSM, scores and prescaler stay in hud_controller.

Verification (TICK_DIV=4, TURN_SECS=15)
REQ-033 Reset, start, 4 clk -> timer 14; after 60 clk total -> 00; next tick -> player 2, timer 15.
REQ-034 Start, match x3, then miss, then match -> p1_score 3, p2_score 1, player 2, timer 15 after each event.
REQ-035 match and miss same cycle with player 1 -> p1_score +1, player stays 1; match coinciding with tick -> timer 15, not 14.
REQ-036 p1 scores 10 matches, game_over -> p1_score 9, winner 1, playing 0; further match/tick -> no change; tie 2-2 -> winner 0.
REQ-037 resetn low mid-PLAY at timer 07, p2_score 4 -> all outputs at reset values same cycle; match after release without start -> ignored.
